// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter.
//   cpu_*  : load/store stage request, store data, read data return, stall
//   ext_*  : burst loader request/descriptor, beat handshake, read return, status
//   mem_*  : the single shared data-memory port
// slave  modport: arbiter side.  master modport: environment (CPU, loader, memory).
interface dmem_port_arbiter_if #(
  parameter int unsigned LEN_W = 8
);
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       cpu_funct3;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;

  logic             ext_start;
  logic             ext_we;
  logic [31:0]      ext_base;
  logic [LEN_W-1:0] ext_len;
  logic             ext_valid;
  logic [31:0]      ext_wdata;
  logic             ext_ready;
  logic [31:0]      ext_rdata;
  logic             ext_rvalid;
  logic             ext_busy;
  logic             ext_done;

  logic             mem_we;
  logic [2:0]       mem_funct3;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_start, ext_we, ext_base, ext_len, ext_valid, ext_wdata,
    output ext_ready, ext_rdata, ext_rvalid, ext_busy, ext_done,
    output mem_we, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_start, ext_we, ext_base, ext_len, ext_valid, ext_wdata,
    input  ext_ready, ext_rdata, ext_rvalid, ext_busy, ext_done,
    input  mem_we, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU load/store
// stage and an external burst loader using request/grant at runtime.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : dmem_port_arbiter_if.slave (cpu_*, ext_*, mem_* groups)
// In IDLE the CPU drives the memory port. A loader request is granted when
// the CPU is idle or after MAX_WAIT refused cycles; the burst then owns the
// port (CPU stalled) until its last beat completes.
module dmem_port_arbiter #(
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic                  clk,
  input logic                  reset,
  dmem_port_arbiter_if.slave   bus
);

  typedef enum logic {
    S_IDLE,
    S_EXT
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        base_q, base_d;
  logic               we_q, we_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               done_q, done_d;

  logic               mem_we_c;
  logic [2:0]         mem_funct3_c;
  logic [31:0]        mem_addr_c;
  logic [31:0]        mem_wdata_c;
  logic               stall_c;
  logic [31:0]        beat_off;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    len_d    = len_q;
    base_d   = base_q;
    we_d     = we_q;
    wait_d   = '0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;

    mem_we_c     = bus.cpu_req & bus.cpu_we;
    mem_funct3_c = bus.cpu_funct3;
    mem_addr_c   = bus.cpu_addr;
    mem_wdata_c  = bus.cpu_wdata;
    stall_c      = 1'b0;
    beat_off     = 32'(beat_q) << 2;

    case (state_q)
      S_IDLE: begin
        if (bus.ext_start) begin
          if (!bus.cpu_req || (wait_q == WAIT_W'(MAX_WAIT))) begin
            // The CPU access of this cycle still goes through; the burst
            // descriptor is captured here and used from the next cycle on.
            base_d = bus.ext_base & ~32'h3;
            len_d  = bus.ext_len;
            we_d   = bus.ext_we;
            beat_d = '0;
            if (bus.ext_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = S_EXT;
            end
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_EXT: begin
        stall_c      = 1'b1;
        mem_funct3_c = 3'b010;
        mem_addr_c   = base_q + beat_off;
        mem_wdata_c  = bus.ext_wdata;
        mem_we_c     = we_q & bus.ext_valid;
        // ext_ready is constant 1 here, so a valid beat always completes.
        if (bus.ext_valid) begin
          beat_d = beat_q + 1'b1;
          if (!we_q) begin
            rdata_d  = bus.mem_rdata;
            rvalid_d = 1'b1;
          end
          if (beat_q == len_q - 1'b1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      len_q    <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      wait_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      base_q   <= base_d;
      we_q     <= we_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  // Reset gates the write enable and the ownership flags combinationally so
  // an abandoned burst cannot write in the cycle reset is applied.
  assign bus.mem_we     = mem_we_c & reset;
  assign bus.mem_funct3 = mem_funct3_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = stall_c & reset;
  assign bus.ext_busy   = stall_c & reset;
  assign bus.ext_ready  = stall_c & reset;
  assign bus.ext_rdata  = rdata_q;
  assign bus.ext_rvalid = rvalid_q;
  assign bus.ext_done   = done_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipelined CPU's load/store stage and an external burst loader, such as a program/debug loader.
- Replaces ad-hoc "load only while in reset" muxing with a request/grant scheme that works at runtime.
- Stalls the CPU while the loader owns the port.
- Bounds the loader's wait with a starvation counter.

Parameters:
- LEN_W, 8: width of the burst length field (beats).
- WAIT_W, 4: width of the starvation counter.
- MAX_WAIT, 15: idle-state cycles the loader may be refused before a forced grant.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-low reset.
- cpu_req, input, 1: CPU memory access this cycle.
- cpu_we, input, 1: CPU store.
- cpu_funct3, input, 3: CPU store/load size code.
- cpu_addr, input, 32: CPU byte address.
- cpu_wdata, input, 32: CPU store data.
- cpu_rdata, output, 32: mem_rdata passed through combinationally.
- cpu_stall, output, 1: CPU must hold its memory-stage state.
- ext_start, input, 1: level burst request; held until ext_busy rises.
- ext_we, input, 1: burst direction (1 = write).
- ext_base, input, 32: burst byte base address.
- ext_len, input, LEN_W: burst beats.
- ext_valid, input, 1: loader beat valid.
- ext_wdata, input, 32: write beat data.
- ext_ready, output, 1: arbiter accepts a beat.
- ext_rdata, output, 32: registered read data.
- ext_rvalid, output, 1: ext_rdata valid.
- ext_busy, output, 1: burst in progress.
- ext_done, output, 1: one-cycle burst-complete pulse.
- mem_we, output, 1: memory write enable.
- mem_funct3, output, 3: memory size code.
- mem_addr, output, 32: memory address.
- mem_wdata, output, 32: memory write data.
- mem_rdata, input, 32: combinational memory read data.

Behaviour:
- States: IDLE, EXT. Registers: state, pending-grant decision, beat counter, latched base/len/we, wait_cnt, ext_rdata, ext_rvalid, ext_done.
- Reset (reset==0 at an edge):
  - state=IDLE; all counters 0.
  - ext_rdata=0, ext_rvalid=0, ext_done=0.
  - mem_we is forced 0 combinationally whenever reset==0.
  - cpu_stall=0, ext_busy=0, ext_ready=0.
  - Reset mid-burst abandons the burst with no further writes and no ext_done.
- IDLE:
  - Memory mux selects CPU: mem_we=cpu_req&cpu_we; mem_funct3/addr/wdata from the cpu_* inputs.
  - cpu_stall=0, ext_ready=0.
- Grant decision, in IDLE with ext_start=1:
  - Grant if cpu_req==0 or wait_cnt==MAX_WAIT; otherwise wait_cnt increments.
  - wait_cnt clears on grant or when ext_start=0.
  - The CPU access in the grant cycle completes normally.
  - At the grant edge, ext_base (bits[1:0] forced 0), ext_len and ext_we are latched.
  - If ext_len==0: stay IDLE, pulse ext_done next cycle, no memory access.
  - Otherwise the next state is EXT.
- EXT:
  - cpu_stall=1, ext_busy=1, ext_ready=1.
  - mem_addr = base + 4*beat, modulo 2^32 (wraps).
  - mem_funct3=3'b010, mem_wdata=ext_wdata, mem_we = latched_we & ext_valid.
  - A beat completes on ext_valid&ext_ready; beat then increments. ext_valid=0 cycles insert gaps, with no access and no advance.
  - Read bursts: on each completed beat, ext_rdata<=mem_rdata and ext_rvalid=1 the following cycle, else 0.
  - On the last beat (beat==len-1 with ext_valid) the next state is IDLE; ext_done=1 for exactly one cycle, coinciding with the final ext_rvalid for reads.
- ext_start is ignored while in EXT. A new request needs ext_start still or again high in IDLE; earliest regrant is the cycle after return.
- cpu_req during EXT is ignored at the memory; the CPU repeats it because it is stalled.
- Latency: grant at least 1 cycle after ext_start; burst of N beats with no gaps occupies exactly N cycles of EXT.

Test Plan:
1. reset=0 for 3 cycles with cpu_req=1, cpu_we=1, ext_start=1 -> mem_we=0, cpu_stall=0, ext_busy=0, ext_done=0, ext_rvalid=0 throughout.
2. cpu_req=0; ext_start, ext_we=1, ext_base=0x100, ext_len=4, ext_valid=1 -> EXT for 4 cycles:
   - writes to 0x100/0x104/0x108/0x10C with mem_funct3=010;
   - cpu_stall=1 for those 4 cycles;
   - ext_done pulse in cycle 5.
3. cpu_req held 1; ext_start raised, MAX_WAIT=15 -> grant after 16 IDLE cycles; ext_busy rises on cycle 17; CPU stores before that complete unstalled.
4. Read burst, base=0x200, len=2, ext_valid pattern 1,0,1:
   - ext_rvalid follows each accepted beat by one cycle with mem[0x200], then mem[0x204];
   - ext_done aligned with the second rvalid.
5. Edge cases:
   - ext_len=0 -> single ext_done pulse, no mem_we, cpu_stall never asserted.
   - Base 0xFFFFFFFC, len=2 -> addresses 0xFFFFFFFC, then 0x00000000.
6. reset=0 asserted after beat 2 of an 8-beat write burst -> next cycle state IDLE, mem_we=0, cpu_stall=0, ext_busy=0, no ext_done; a fresh burst after release starts at beat 0.
